ysyx_23060236_tlb: RTL and testbench

YSYX_23060236_TLB -- requirements
Module: ysyx_23060236_tlb

---
 rtl/ysyx_23060236_tlb.sv | 84 ++++++++
 tb/tb_ysyx_23060236_tlb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060236_tlb.sv
// ysyx_23060236_tlb: fully-associative VPN->PPN cache with in-place update, lowest-free fill
// and round-robin replacement once full; lookups see the table as it stood before the edge.
module ysyx_23060236_tlb #(
  parameter int ENTRIES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        tlb_rvalid,
  input  logic [19:0] tlb_araddr,
  output logic        tlb_hit,
  output logic [19:0] tlb_rdata,
  input  logic        tlb_wvalid,
  input  logic [19:0] tlb_awaddr,
  input  logic [19:0] tlb_wdata
);
  localparam int IW = $clog2(ENTRIES);

  logic [ENTRIES-1:0] r_valid;
  logic [19:0]        r_vpn [ENTRIES];
  logic [19:0]        r_ppn [ENTRIES];
  logic [IW-1:0]      r_rp;

  logic          w_rhit;
  logic [19:0]   w_rppn;
  logic          w_whit;
  logic [IW-1:0] w_midx;
  logic [IW-1:0] w_fidx;
  logic          w_full;
  logic [IW-1:0] w_widx;

  // Tags are never duplicated, so OR-ing the matching PPNs yields the single hit.
  always_comb begin
    w_rhit = 1'b0;
    w_rppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_rhit = w_rhit | (r_valid[i] && r_vpn[i] == tlb_araddr);
      w_rppn = w_rppn | ((r_valid[i] && r_vpn[i] == tlb_araddr) ? r_ppn[i] : 20'h0);
    end
  end

  // Scanning downward leaves the lowest matching / lowest free index.
  always_comb begin
    w_whit = 1'b0;
    w_midx = '0;
    w_fidx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && r_vpn[i] == tlb_awaddr) begin
        w_whit = 1'b1;
        w_midx = IW'(i);
      end
      if (!r_valid[i]) w_fidx = IW'(i);
    end
  end

  assign w_full = &r_valid;
  assign w_widx = w_whit ? w_midx : (w_full ? r_rp : w_fidx);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_valid   <= '0;
      r_rp      <= '0;
      tlb_hit   <= 1'b0;
      tlb_rdata <= '0;
    end else begin
      if (tlb_rvalid) begin
        tlb_hit   <= w_rhit;
        tlb_rdata <= w_rppn;
      end
      if (tlb_wvalid) begin
        r_valid[w_widx] <= 1'b1;
        if (!w_whit && w_full) r_rp <= r_rp + IW'(1);
      end
    end
  end

  // Tag/PPN storage has no reset: stale contents are masked by the valid bits.
  always_ff @(posedge clock) begin
    if (!reset && !flush && tlb_wvalid) begin
      r_vpn[w_widx] <= tlb_awaddr;
      r_ppn[w_widx] <= tlb_wdata;
    end
  end
endmodule

// File: tb/tb_ysyx_23060236_tlb.sv
// tb_ysyx_23060236_tlb: directed and random stimulus against a reference model of the table.
module tb_ysyx_23060236_tlb;
  localparam int N = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        tlb_rvalid = 1'b0;
  logic [19:0] tlb_araddr = '0;
  logic        tlb_hit;
  logic [19:0] tlb_rdata;
  logic        tlb_wvalid = 1'b0;
  logic [19:0] tlb_awaddr = '0;
  logic [19:0] tlb_wdata = '0;

  int vectors = 0;
  int errors = 0;

  bit          m_valid [N];
  logic [19:0] m_vpn [N];
  logic [19:0] m_ppn [N];
  int          m_rp = 0;
  bit          m_hit = 0;
  logic [19:0] m_rdata = '0;

  ysyx_23060236_tlb #(.ENTRIES(N)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .tlb_rvalid(tlb_rvalid), .tlb_araddr(tlb_araddr),
    .tlb_hit(tlb_hit), .tlb_rdata(tlb_rdata),
    .tlb_wvalid(tlb_wvalid), .tlb_awaddr(tlb_awaddr), .tlb_wdata(tlb_wdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rs, input bit fl, input bit rv, input logic [19:0] ra,
                       input bit wv, input logic [19:0] wa, input logic [19:0] wd);
    int slot;
    if (rs || fl) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_rp = 0;
      m_hit = 0;
      m_rdata = '0;
      return;
    end
    if (rv) begin
      m_hit = 0;
      m_rdata = '0;
      foreach (m_valid[i]) if (m_valid[i] && m_vpn[i] == ra) begin
        m_hit = 1;
        m_rdata = m_ppn[i];
      end
    end
    if (wv) begin
      slot = -1;
      foreach (m_valid[i]) if (slot < 0 && m_valid[i] && m_vpn[i] == wa) slot = i;
      foreach (m_valid[i]) if (slot < 0 && !m_valid[i]) slot = i;
      if (slot < 0) begin
        slot = m_rp;
        m_rp = (m_rp + 1) % N;
      end
      m_valid[slot] = 1;
      m_vpn[slot] = wa;
      m_ppn[slot] = wd;
    end
  endtask

  task automatic cyc(input bit rs, input bit fl, input bit rv, input logic [19:0] ra,
                     input bit wv, input logic [19:0] wa, input logic [19:0] wd);
    reset = rs; flush = fl; tlb_rvalid = rv; tlb_araddr = ra;
    tlb_wvalid = wv; tlb_awaddr = wa; tlb_wdata = wd;
    @(posedge clock);
    model(rs, fl, rv, ra, wv, wa, wd);
    #1;
    chk("hit", {19'h0, tlb_hit}, {19'h0, m_hit});
    chk("rdata", tlb_rdata, m_rdata);
  endtask

  task automatic rst();
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic lk(input logic [19:0] a);
    cyc(0, 0, 1, a, 0, 0, 0);
  endtask
  task automatic fill(input logic [19:0] a, input logic [19:0] d);
    cyc(0, 0, 0, 0, 1, a, d);
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst(); rst();
    chk("reset_hit", {19'h0, tlb_hit}, 20'h0);
    chk("reset_rdata", tlb_rdata, 20'h0);

    fill(20'h80001, 20'h12345);
    lk(20'h80001);
    chk("basic_hit", {19'h0, tlb_hit}, 20'h1);
    chk("basic_rdata", tlb_rdata, 20'h12345);
    lk(20'h80002);
    chk("basic_miss", {19'h0, tlb_hit}, 20'h0);
    chk("basic_miss_rdata", tlb_rdata, 20'h0);

    rst();
    for (int i = 1; i <= 8; i++) fill(20'(i), 20'(i + 'h100));
    for (int i = 1; i <= 8; i++) lk(20'(i));
    fill(20'h9, 20'h109);
    lk(20'h1);
    chk("evict_1", {19'h0, tlb_hit}, 20'h0);
    fill(20'hA, 20'h10A);
    lk(20'h2);
    chk("evict_2", {19'h0, tlb_hit}, 20'h0);
    lk(20'h3);
    chk("keep_3", tlb_rdata, 20'h103);
    for (int i = 'hB; i <= 'h12; i++) fill(20'(i), 20'(i + 'h100));
    fill(20'h13, 20'h113);
    for (int i = 1; i <= 'h13; i++) lk(20'(i));
    lk(20'h12);
    chk("wrap_keep_12", tlb_rdata, 20'h112);
    lk(20'hB);
    chk("wrap_evict_b", {19'h0, tlb_hit}, 20'h0);

    rst();
    fill(20'h5, 20'hAAAAA);
    fill(20'h5, 20'hBBBBB);
    lk(20'h5);
    chk("update_ppn", tlb_rdata, 20'hBBBBB);
    for (int i = 'h20; i < 'h27; i++) fill(20'(i), 20'(i));
    fill(20'h30, 20'h30);
    lk(20'h5);
    chk("update_single_slot", {19'h0, tlb_hit}, 20'h0);

    rst();
    cyc(0, 0, 1, 20'h7, 1, 20'h7, 20'h77777);
    chk("same_cycle_miss", {19'h0, tlb_hit}, 20'h0);
    lk(20'h7);
    chk("same_cycle_next_hit", {19'h0, tlb_hit}, 20'h1);

    rst();
    for (int i = 0; i < 4; i++) fill(20'(i + 'h40), 20'(i + 'h900));
    lk(20'h42);
    idle(); idle();
    chk("hold_rdata", tlb_rdata, 20'h902);
    cyc(0, 1, 1, 20'h41, 1, 20'h50, 20'h950);
    chk("flush_hit", {19'h0, tlb_hit}, 20'h0);
    chk("flush_rdata", tlb_rdata, 20'h0);
    for (int i = 0; i < 4; i++) lk(20'(i + 'h40));
    lk(20'h50);
    chk("flush_dropped_fill", {19'h0, tlb_hit}, 20'h0);

    fill(20'h3, 20'h333);
    fill(20'h4, 20'h444);
    cyc(1, 1, 1, 20'h3, 1, 20'h3, 20'h333);
    lk(20'h3);
    chk("reset_mid_miss", {19'h0, tlb_hit}, 20'h0);
    for (int i = 0; i < 9; i++) fill(20'(i + 'h60), 20'(i + 'hA00));
    lk(20'h60);
    chk("reset_evict_0", {19'h0, tlb_hit}, 20'h0);
    lk(20'h61);
    chk("reset_keep_1", tlb_rdata, 20'hA01);

    for (int k = 0; k < 1500; k++) begin
      logic [19:0] ra, wa, wd;
      ra = ($urandom_range(0, 15) == 0) ? 20'($urandom) : 20'($urandom_range(0, 11));
      wa = ($urandom_range(0, 15) == 0) ? 20'($urandom) : 20'($urandom_range(0, 11));
      wd = 20'($urandom);
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
          1'($urandom), ra, 1'($urandom), wa, wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
